// File: rtl/arashi_thread_cache_mt_if.sv
// arashi_thread_cache_mt_if: shared write port plus arbitrated pop port
// for the multi-thread cache; master drives requests, slave answers.
interface arashi_thread_cache_mt_if #(
  parameter int DATA_WIDTH = 32,
  parameter int THREADS    = 4
);
  localparam int TID_W = $clog2(THREADS);

  logic                  w_ena;
  logic [TID_W-1:0]      w_tid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  w_ready;
  logic                  r_ena;
  logic                  r_valid;
  logic [TID_W-1:0]      r_tid;
  logic [DATA_WIDTH-1:0] data_out;
  logic [THREADS-1:0]    avail;
  logic [THREADS-1:0]    full;

  modport master (
    output w_ena, w_tid, data_in, r_ena,
    input  w_ready, r_valid, r_tid, data_out,
    input  avail, full
  );

  modport slave (
    input  w_ena, w_tid, data_in, r_ena,
    output w_ready, r_valid, r_tid, data_out,
    output avail, full
  );
endinterface

// File: rtl/arashi_thread_cache_mt.sv
// arashi_thread_cache_mt: THREADS independent FIFOs behind one write port
// and a round-robin pop port with registered output and lookahead avail.
module arashi_thread_cache_mt #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int THREADS    = 4
) (
  input logic                      clk,
  input logic                      rst,
  arashi_thread_cache_mt_if.slave  bus
);
  localparam int TID_W = $clog2(THREADS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] buff [THREADS][DEPTH];
  logic [PTR_W-1:0]      w_ptr [THREADS];
  logic [PTR_W-1:0]      r_ptr [THREADS];
  logic [CNT_W-1:0]      count [THREADS];
  logic [TID_W-1:0]      last_gnt;
  logic [TID_W-1:0]      gnt;
  logic                  any;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [THREADS-1:0]    wr_hit;
  logic [THREADS-1:0]    rd_hit;
  logic [THREADS-1:0]    full_v;
  logic [THREADS-1:0]    avail_v;
  logic                  r_valid_q;
  logic [TID_W-1:0]      r_tid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // round-robin grant over registered counts, starting after last_gnt
  always_comb begin
    int idx;
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 1; i <= THREADS; i++) begin
      idx = (int'(last_gnt) + i) % THREADS;
      if (!any && count[idx] != '0) begin
        any = 1'b1;
        gnt = TID_W'(idx);
      end
    end
  end

  // accept/pop decode and per-thread status
  always_comb begin
    wr_acc  = bus.w_ena && !full_v[bus.w_tid];
    rd_acc  = bus.r_ena && any;
    wr_hit  = '0;
    rd_hit  = '0;
    full_v  = '0;
    avail_v = '0;
    for (int t = 0; t < THREADS; t++) begin
      full_v[t] = (count[t] == CNT_W'(DEPTH));
    end
    wr_acc = bus.w_ena && !full_v[bus.w_tid];
    for (int t = 0; t < THREADS; t++) begin
      wr_hit[t] = wr_acc && (bus.w_tid == TID_W'(t));
      rd_hit[t] = rd_acc && (gnt == TID_W'(t));
      if (count[t] == '0)
        avail_v[t] = bus.w_ena && (bus.w_tid == TID_W'(t));
      else if (count[t] == CNT_W'(1))
        avail_v[t] = !(rd_hit[t] && !wr_hit[t]);
      else
        avail_v[t] = 1'b1;
    end
  end

  // entry storage; not reset
  always_ff @(posedge clk) begin
    if (wr_acc)
      buff[bus.w_tid][w_ptr[bus.w_tid]] <= bus.data_in;
  end

  // pointers, counts, arbiter state and registered pop output
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        w_ptr[t] <= '0;
        r_ptr[t] <= '0;
        count[t] <= '0;
      end
      last_gnt  <= TID_W'(THREADS - 1);
      r_valid_q <= 1'b0;
      r_tid_q   <= '0;
      data_q    <= '0;
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        if (wr_hit[t])
          w_ptr[t] <= w_ptr[t] + PTR_W'(1);
        if (rd_hit[t])
          r_ptr[t] <= r_ptr[t] + PTR_W'(1);
        if (wr_hit[t] && !rd_hit[t])
          count[t] <= count[t] + CNT_W'(1);
        else if (!wr_hit[t] && rd_hit[t])
          count[t] <= count[t] - CNT_W'(1);
      end
      r_valid_q <= rd_acc;
      if (rd_acc) begin
        data_q   <= buff[gnt][r_ptr[gnt]];
        r_tid_q  <= gnt;
        last_gnt <= gnt;
      end
    end
  end

  assign bus.w_ready  = !full_v[bus.w_tid];
  assign bus.full     = full_v;
  assign bus.avail    = avail_v;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_tid    = r_tid_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_arashi_thread_cache_mt.sv
// tb_arashi_thread_cache_mt: directed vectors for the multi-thread
// cache with hand-computed expectations.
module tb_arashi_thread_cache_mt;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  arashi_thread_cache_mt_if #(.DATA_WIDTH(32), .THREADS(4)) bus ();

  arashi_thread_cache_mt #(
    .DATA_WIDTH(32),
    .DEPTH(4),
    .THREADS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] tid,
                       input logic [31:0] d, input logic re);
    bus.w_ena   = we;
    bus.w_tid   = tid;
    bus.data_in = d;
    bus.r_ena   = re;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] tid,
                         input logic [31:0] d);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    chk({tag, ".v"}, bus.r_valid, 1);
    chk({tag, ".t"}, bus.r_tid, tid);
    chk({tag, ".d"}, bus.data_out, d);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    tick();

    // 1: reset state, basic write/pop on thread 2
    do_reset();
    chk("rst.v", bus.r_valid, 0);
    chk("rst.d", bus.data_out, 0);
    chk("rst.t", bus.r_tid, 0);
    chk("rst.full", bus.full, 4'h0);
    chk("rst.avail", bus.avail, 4'h0);
    chk("rst.wrdy", bus.w_ready, 1);
    drive(1'b1, 2'd2, 32'hA, 1'b0);
    chk("t1.avail", bus.avail, 4'h4);
    tick();
    drive(1'b1, 2'd2, 32'hB, 1'b0);
    tick();
    pop_chk("t1.p0", 2'd2, 32'hA);
    pop_chk("t1.p1", 2'd2, 32'hB);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("t1.empty.v", bus.r_valid, 0);
    chk("t1.hold.d", bus.data_out, 32'hB);

    // 2: fill thread 1, overflow dropped, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 32'h10 + i, 1'b0);
      tick();
    end
    drive(1'b0, 2'd1, 32'h0, 1'b0);
    chk("t2.full", bus.full, 4'h2);
    chk("t2.wrdy", bus.w_ready, 0);
    drive(1'b1, 2'd1, 32'h99, 1'b0);
    tick();
    chk("t2.full2", bus.full, 4'h2);
    drive(1'b1, 2'd1, 32'h98, 1'b1);
    chk("t2.popfull.wrdy", bus.w_ready, 0);
    tick();
    chk("t2.d0", bus.data_out, 32'h10);
    chk("t2.nfull", bus.full, 4'h0);
    pop_chk("t2.d1", 2'd1, 32'h11);
    pop_chk("t2.d2", 2'd1, 32'h12);
    pop_chk("t2.d3", 2'd1, 32'h13);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("t2.nomore", bus.r_valid, 0);

    // 3: round-robin grant order
    do_reset();
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 2'(t), 32'h20 + t, 1'b0);
      tick();
    end
    chk("t3.avail", bus.avail, 4'hF);
    for (int t = 0; t < 4; t++)
      pop_chk("t3.rr", 2'(t), 32'h20 + t);
    drive(1'b1, 2'd0, 32'h30, 1'b0);
    tick();
    drive(1'b1, 2'd3, 32'h33, 1'b0);
    tick();
    pop_chk("t3.rr2a", 2'd0, 32'h30);
    pop_chk("t3.rr2b", 2'd3, 32'h33);

    // 4: lookahead avail, no write-to-read bypass
    drive(1'b1, 2'd0, 32'h44, 1'b1);
    chk("t4.avail", bus.avail, 4'h1);
    tick();
    chk("t4.nobyp", bus.r_valid, 0);
    pop_chk("t4.p", 2'd0, 32'h44);

    // 5: count-1 pop lookahead, write+pop same thread
    drive(1'b1, 2'd3, 32'h55, 1'b0);
    tick();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    chk("t5.idle", bus.avail, 4'h8);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    chk("t5.pop", bus.avail, 4'h0);
    drive(1'b1, 2'd3, 32'h56, 1'b1);
    chk("t5.wrpop", bus.avail, 4'h8);
    tick();
    chk("t5.p0", bus.data_out, 32'h55);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    chk("t5.cnt1", bus.avail, 4'h0);
    tick();
    chk("t5.p1", bus.data_out, 32'h56);
    chk("t5.p1.t", bus.r_tid, 3);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("t5.empty", bus.r_valid, 0);

    // 6: reset mid-drain
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'd1, 32'h60 + i, 1'b0);
      tick();
    end
    pop_chk("t6.p", 2'd1, 32'h61);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    chk("t6.v", bus.r_valid, 0);
    chk("t6.d", bus.data_out, 0);
    chk("t6.full", bus.full, 4'h0);
    chk("t6.avail", bus.avail, 4'h0);
    drive(1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    chk("t6.after", bus.r_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
